// File: rtl/sync_fifo_marker.sv
// Parametrised single-clock FIFO with occupancy flags, sticky error flags and an
// optional frame-marker translator that inserts MARK_OUT after each popped MARK_IN.
module sync_fifo_marker #(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      ADDR_WIDTH = 10,
  parameter int unsigned      AF_LEVEL   = 1023,
  parameter int unsigned      AE_LEVEL   = 1,
  parameter bit               MARK_EN    = 1'b1,
  parameter logic [WIDTH-1:0] MARK_IN    = 16'hFAF1,
  parameter logic [WIDTH-1:0] MARK_OUT   = 16'hF1FA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  rd_stall,
  input  logic                  flag_clr,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_AF = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LP_AE = AE_LEVEL[ADDR_WIDTH:0];

  typedef enum logic {S_IDLE, S_INSERT} state_t;

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_rd_valid, r_overflow, r_underflow;
  logic [ADDR_WIDTH:0] w_count;
  logic [WIDTH-1:0]    w_rd_word;
  logic                w_full, w_empty, w_stall;
  logic                w_wr_accept, w_pop, w_ovf_set, w_udf_set;

  // Extra MSB on each pointer is the wrap bit that tells full from empty.
  assign w_full    = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_stall   = (r_state == S_INSERT);
  assign w_rd_word = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

  assign w_wr_accept = wr_en && !w_full;
  assign w_pop       = rd_en && !w_empty && !w_stall;
  assign w_ovf_set   = wr_en && w_full;
  assign w_udf_set   = rd_en && w_empty && !w_stall;

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign rd_stall     = w_stall;
  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign almost_full  = (w_count >= LP_AF);
  assign almost_empty = (w_count <= LP_AE);
  assign fifo_count   = w_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // NOTE: storage is deliberately left out of reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_state     <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_stall) begin
        r_rd_data  <= MARK_OUT;
        r_rd_valid <= 1'b1;
      end else if (w_pop) begin
        r_rd_data  <= w_rd_word;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end

      // A new error in the same cycle as flag_clr wins.
      r_overflow  <= w_ovf_set | (r_overflow  & ~flag_clr);
      r_underflow <= w_udf_set | (r_underflow & ~flag_clr);
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (MARK_EN && w_pop && (w_rd_word == MARK_IN)) w_state_nxt = S_INSERT;
      S_INSERT: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sync_fifo_marker.sv
// Self-checking bench for sync_fifo_marker: queue-based reference model with a
// scoreboard of expected read words, a vector table and directed corner sequences.
module tb_sync_fifo_marker;

  localparam int          DEPTH    = 1024;
  localparam int          AF_LEVEL = 1023;
  localparam int          AE_LEVEL = 1;
  localparam logic [15:0] MARK_IN  = 16'hFAF1;
  localparam logic [15:0] MARK_OUT = 16'hF1FA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, flag_clr = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic        rd_valid, rd_stall, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [10:0] fifo_count;
  logic        overflow, underflow;

  sync_fifo_marker dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_stall(rd_stall), .flag_clr(flag_clr),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_count(fifo_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference model state
  logic [15:0] mdl[$];
  logic [15:0] sb[$];
  bit          mdl_stall, mdl_ovf, mdl_udf;
  logic [15:0] last_data;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        re;
    logic [10:0] exp_count;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(mdl.size()));
    check({tag, "_empty"}, 32'(fifo_empty), 32'(mdl.size() == 0));
    check({tag, "_full"}, 32'(fifo_full), 32'(mdl.size() == DEPTH));
    check({tag, "_afull"}, 32'(almost_full), 32'(mdl.size() >= AF_LEVEL));
    check({tag, "_aempty"}, 32'(almost_empty), 32'(mdl.size() <= AE_LEVEL));
    check({tag, "_ovf"}, 32'(overflow), 32'(mdl_ovf));
    check({tag, "_udf"}, 32'(underflow), 32'(mdl_udf));
    check({tag, "_stall"}, 32'(rd_stall), 32'(mdl_stall));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic we, input logic [15:0] wd, input logic re, input logic fc);
    bit          pre_full, pre_empty, pre_stall, do_pop, exp_valid;
    logic [15:0] w;
    pre_full  = (mdl.size() == DEPTH);
    pre_empty = (mdl.size() == 0);
    pre_stall = mdl_stall;
    do_pop    = re && !pre_empty && !pre_stall;
    exp_valid = do_pop || pre_stall;
    wr_en = we; wr_data = wd; rd_en = re; flag_clr = fc;
    mdl_stall = 1'b0;
    if (do_pop) begin
      w = mdl.pop_front();
      sb.push_back(w);
      if (w == MARK_IN) begin
        sb.push_back(MARK_OUT);
        mdl_stall = 1'b1;
      end
    end
    if (we && !pre_full) mdl.push_back(wd);
    mdl_ovf = (we && pre_full) || (mdl_ovf && !fc);
    mdl_udf = (re && pre_empty && !pre_stall) || (mdl_udf && !fc);
    @(posedge clk); #1;
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underrun at %0t: got rd_valid with data %0h, required no output", $time, rd_data);
      end else begin
        w = sb.pop_front();
        check("rd_data", 32'(rd_data), 32'(w));
        last_data = w;
      end
    end else begin
      check("rd_hold", 32'(rd_data), 32'(last_data));
    end
    check_state("cyc");
  endtask

  // Caller sets the other inputs; rst is asserted off-edge to exercise the async path.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #2;
    mdl.delete(); sb.delete();
    mdl_stall = 1'b0; mdl_ovf = 1'b0; mdl_udf = 1'b0; last_data = '0;
    check({tag, "_async_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_async_empty"}, 32'(fifo_empty), 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flag_clr = 1'b0;
    check_state(tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int          stall_cnt;
    logic [15:0] got[$];
    logic [15:0] exp_seq [4];

    tbl[0] = '{1'b1, 16'h0001, 1'b0, 11'd1, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 16'h0002, 1'b0, 11'd2, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 16'h0003, 1'b0, 11'd3, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, 16'h0004, 1'b0, 11'd4, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 11'd3, 1'b1, 16'h0001};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 11'd2, 1'b1, 16'h0002};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 11'd1, 1'b1, 16'h0003};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 11'd0, 1'b1, 16'h0004};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 11'd0, 1'b0, 16'h0004};
    exp_seq = '{16'h0010, 16'hFAF1, 16'hF1FA, 16'h0020};

    apply_reset("reset");
    check("reset_aempty", 32'(almost_empty), 32'd1);

    // Basic write/read through the vector table
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].we, tbl[i].wd, tbl[i].re, 1'b0);
      check($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].exp_count));
      check($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
    end
    check("tbl_empty_end", 32'(fifo_empty), 32'd1);

    // Fill to full, overflow, clear
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 1021) check("afull_at_1022", 32'(almost_full), 32'd0);
      if (i == 1022) check("afull_at_1023", 32'(almost_full), 32'd1);
    end
    check("full_set", 32'(fifo_full), 32'd1);
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count_held", 32'(fifo_count), 32'd1024);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("full_write_with_pop_dropped", 32'(fifo_count), 32'd1023);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Drain, then underflow corner cases
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("drained_empty", 32'(fifo_empty), 32'd1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("udf_set", 32'(underflow), 32'd1);
    check("udf_no_valid", 32'(rd_valid), 32'd0);
    check("udf_data_held", 32'(rd_data), 32'd1023);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    check("udf_set_wins_clr", 32'(underflow), 32'd1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    check("udf_clr", 32'(underflow), 32'd0);
    cycle(1'b1, 16'h0055, 1'b1, 1'b0);
    check("empty_read_with_write", 32'(underflow), 32'd1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    check("late_word_popped", 32'(rd_data), 32'h0055);

    // Marker translation
    cycle(1'b1, 16'h0010, 1'b0, 1'b0);
    cycle(1'b1, 16'hFAF1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0020, 1'b0, 1'b0);
    stall_cnt = 0;
    got.delete();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      if (rd_stall) stall_cnt++;
      if (rd_valid) got.push_back(rd_data);
    end
    check("mark_stall_cycles", 32'(stall_cnt), 32'd1);
    check("mark_out_words", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) check($sformatf("mark_seq%0d", i), 32'(got[i]), 32'(exp_seq[i]));
    check("mark_drained", 32'(fifo_empty), 32'd1);
    check("mark_no_udf", 32'(underflow), 32'd0);

    // Back-to-back markers each get their own insertion
    cycle(1'b1, MARK_IN, 1'b0, 1'b0);
    cycle(1'b1, MARK_IN, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("b2b_last_word", 32'(rd_data), 32'(MARK_OUT));

    // Sustained simultaneous write/read at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) cycle(1'b1, 16'h1003 + 16'(i), 1'b1, 1'b0);
    check("wrap_count", 32'(fifo_count), 32'd3);
    check("wrap_no_ovf", 32'(overflow), 32'd0);
    check("wrap_no_udf", 32'(underflow), 32'd0);
    check("wrap_last_data", 32'(rd_data), 32'h17CF);

    // Reset mid-burst with sticky flag set
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 500; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    check("burst_count_500", 32'(fifo_count), 32'd500);
    check("burst_sb_empty", 32'(sb.size()), 32'd0);
    wr_en = 1'b1; wr_data = 16'h2222;
    apply_reset("midrst");
    check("midrst_udf", 32'(underflow), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    cycle(1'b1, 16'h0077, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("post_rst_data", 32'(rd_data), 32'h0077);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_marker.md
Name: sync_fifo_marker

Overview:
Parametrised synchronous FIFO for inter-layer spike/word streams. It replaces the fixed 16-bit, 1024-deep layer FIFO with a configurable width and depth, programmable almost-full/almost-empty levels, an occupancy count and sticky error flags. A parameter-enabled frame-marker translator emits MARK_OUT on the cycle after a popped MARK_IN word. The block sits between producer and consumer layers of the hybrid pipeline, all in one clock domain.

Parameters:
WIDTH, 16, data word width in bits
ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH (power of two only)
AF_LEVEL, 1023, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
MARK_EN, 1, 1 = marker translation on; 0 = plain FIFO
MARK_IN, 16'hFAF1, popped word that triggers translation (WIDTH bits)
MARK_OUT, 16'hF1FA, word inserted after MARK_IN (WIDTH bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
wr_en  in  1  write request
wr_data  in  WIDTH  write data
rd_en  in  1  read (pop) request
rd_data  out  WIDTH  registered read data
rd_valid  out  1  rd_data updated this cycle (pop or inserted marker)
rd_stall  out  1  marker insertion cycle; rd_en ignored
flag_clr  in  1  synchronous clear of overflow/underflow
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
fifo_count  out  ADDR_WIDTH+1  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty and not stalled

Behaviour:
- Reset (async, rst=1) clears wr_ptr, rd_ptr, rd_data, rd_valid, rd_stall, overflow and underflow, and puts the FSM in IDLE. Storage array is not reset (contents are don't-care). After reset: fifo_empty=1, almost_empty=1, fifo_full=0, fifo_count=0.
- Pointers are ADDR_WIDTH+1 bits wide. The MSB is the wrap bit. full = MSBs differ and low bits are equal; empty = pointers equal. fifo_count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Write accepted iff wr_en && !fifo_full. The word is stored at wr_ptr and wr_ptr increments. When full, the write is dropped and overflow is set.
- Pop iff rd_en && !fifo_empty && !rd_stall. On a pop, rd_data <= mem[rd_ptr] on the next edge (1-cycle latency), rd_valid=1 for that cycle, and rd_ptr increments.
- rd_en while empty and not stalled: no pop and underflow is set. rd_en while stalled: ignored, no flag.
- Without a pop or insertion, rd_data holds its value and rd_valid=0.
- All flags are derived combinationally from the pointers, so they reflect the state after the last edge. Full/empty use the registered state: a write while full is rejected even if a read pops in the same cycle, and a read while empty is rejected even if a write lands in the same cycle.
- Simultaneous accepted write and pop: count unchanged; both pointers advance. Pointers wrap naturally with no special case.
- FSM (only when MARK_EN=1):
  - IDLE: on a pop whose data equals MARK_IN -> INSERT.
  - INSERT (one cycle): rd_stall=1. At the next edge rd_data <= MARK_OUT and rd_valid=1, with no pop and rd_ptr unchanged; then -> IDLE.
  - Back-to-back MARK_IN words each trigger their own insertion, so the output is MARK_IN, MARK_OUT, MARK_IN, MARK_OUT.
- MARK_EN=0: FSM stays in IDLE and rd_stall is held at 0.
- flag_clr clears overflow and underflow. If a new error occurs in the same cycle as flag_clr, the flag is set (set wins).
- Reset mid-operation: all pointers and flags return to reset values on the same rst assertion. Stored data is lost.

Test Plan:
- Reset, then write 0x0001..0x0004, then pop 4 -> rd_data 0x0001..0x0004, each one cycle after rd_en with rd_valid=1; fifo_count 4->0; fifo_empty=1 at end.
- Fill 1024 words -> fifo_full=1 and almost_full=1 from count 1023; 1025th write -> overflow=1, count stays 1024; flag_clr -> overflow=0.
- Pop on empty FIFO -> underflow=1, rd_data holds its old value, rd_valid=0.
- Write 0x0010, 0xFAF1, 0x0020; read continuously -> rd_data sequence 0x0010, 0xFAF1, 0xF1FA, 0x0020; rd_stall=1 for exactly one cycle, and the rd_en asserted in that cycle does not pop.
- Hold simultaneous wr_en/rd_en at count=3 for 2000 cycles across pointer wrap -> count stays 3, data order preserved, no flags set.
- Assert rst mid-burst at count=500 -> next cycle count=0, fifo_empty=1, rd_data=0, overflow=0, underflow=0.
